// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stall/flush controls between the
// pipeline datapath (master) and the hazard sequencer (slave).
// The performance-counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  imem_ready;
    logic                  mem_req;
    logic                  dmem_ready;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_ex_stall;
    logic                  ex_mem_stall;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  mem_wb_bubble;
    logic                  mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      redirect_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready, mem_req, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_wb_bubble, mem_timeout, stall_cycles, redirect_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready, mem_req, dmem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_wb_bubble, mem_timeout, stall_cycles, redirect_count
    );
`else
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready, mem_req, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_wb_bubble, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready, mem_req, dmem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_wb_bubble, mem_timeout
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage core.
// The FSM suppresses a double stall on load-use, squashes the in-flight wrong-path
// fetch after a redirect, and trips a sticky fault on over-long data-memory waits.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/redirect counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TMO = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {RUN, LOAD_STALL, REDIRECT, DMEM_WAIT, FAULT} state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
    logic                tmo_q, tmo_d;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                lu, freeze_req;
    logic                freeze, rules, lu_en, enter_wait;
    logic                pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic                if_id_flush, id_ex_flush, mem_wb_bubble;

    assign rs1        = hz.id_rs1;
    assign rs2        = hz.id_rs2;
    assign rd         = hz.ex_rd;
    assign lu         = hz.ex_mem_read && (rd != '0) &&
                        ((hz.id_uses_rs1 && (rs1 == rd)) || (hz.id_uses_rs2 && (rs2 == rd)));
    assign freeze_req = hz.mem_req && !hz.dmem_ready;
    assign wcnt_inc   = wcnt_q + 1'b1;

    // Next-state and Mealy control outputs; the per-state case only selects which
    // rule set applies, the shared freeze / RUN-priority logic follows it.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        tmo_d         = tmo_q;
        freeze        = 1'b0;
        rules         = 1'b0;
        lu_en         = 1'b0;
        enter_wait    = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        unique case (state_q)
            RUN, LOAD_STALL: begin
                if (freeze_req) begin
                    freeze     = 1'b1;
                    enter_wait = 1'b1;
                end else begin
                    rules   = 1'b1;
                    lu_en   = (state_q == RUN);
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                if (freeze_req) begin
                    freeze     = 1'b1;
                    enter_wait = 1'b1;
                end else begin
                    if_id_flush = 1'b1;
                    state_d     = RUN;
                end
            end
            DMEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    freeze = 1'b1;
                    if (wcnt_inc >= TMO) begin
                        state_d = FAULT;
                        wcnt_d  = '0;
                        tmo_d   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_inc;
                    end
                end else begin
                    wcnt_d  = '0;
                    rules   = 1'b1;
                    lu_en   = 1'b1;
                    state_d = RUN;
                end
            end
            FAULT: begin
                freeze = 1'b1;
                tmo_d  = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (enter_wait) begin
            state_d = DMEM_WAIT;
            wcnt_d  = WCNT_W'(1);
            if (MEM_TIMEOUT <= 1) begin
                state_d = FAULT;
                wcnt_d  = '0;
                tmo_d   = 1'b1;
            end
        end

        if (freeze) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end

        if (rules) begin
            if (hz.ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_d     = REDIRECT;
            end else if (lu_en && lu) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                state_d     = LOAD_STALL;
            end else if (!hz.imem_ready) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_stall      = 1'b0;
            if_id_stall   = 1'b0;
            id_ex_stall   = 1'b0;
            ex_mem_stall  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign hz.pc_stall      = pc_stall;
    assign hz.if_id_stall   = if_id_stall;
    assign hz.id_ex_stall   = id_ex_stall;
    assign hz.ex_mem_stall  = ex_mem_stall;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.mem_timeout   = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, redir_cnt_q;

    // Saturating performance counters: stalled PC cycles and redirect entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((state_d == REDIRECT) && (state_q != REDIRECT) && (redir_cnt_q != '1))
                redir_cnt_q <= redir_cnt_q + 1'b1;
        end
    end

    assign hz.stall_cycles   = stall_cnt_q;
    assign hz.redirect_count = redir_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed control patterns.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic       mem_read;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       br;
        logic       imem;
        logic       req;
        logic       dready;
    } vec_t;

    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] SQ   = 7'b0000100;
    localparam logic [6:0] FRZ  = 7'b1111001;
    localparam logic [6:0] IMW  = 7'b1000100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_stall = 0;
    int   exp_redir = 0;
    logic [6:0] ctl;

    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz_if)
    );

    always #5 clk = ~clk;

    assign ctl = {hz_if.pc_stall, hz_if.if_id_stall, hz_if.id_ex_stall, hz_if.ex_mem_stall,
                  hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.mem_wb_bubble};

    // lu: 0 none, 1 load rd5 vs rs2=5, 2 load rd0, 3 rd7=rs1 unused, 4 rd7=rs1 used, 5 rd5=rs2 non-load
    function automatic vec_t mk(input int lu, input logic br, input logic imem,
                                input logic req, input logic dready);
        vec_t v;
        v = '0;
        v.br = br; v.imem = imem; v.req = req; v.dready = dready;
        case (lu)
            1: begin v.mem_read = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.u2 = 1'b1; end
            2: begin v.mem_read = 1'b1; v.rd = 5'd0; v.rs2 = 5'd0; v.u2 = 1'b1; end
            3: begin v.mem_read = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7; v.u1 = 1'b0; end
            4: begin v.mem_read = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7; v.u1 = 1'b1; end
            5: begin v.mem_read = 1'b0; v.rd = 5'd5; v.rs2 = 5'd5; v.u2 = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic apply(input vec_t v);
        hz_if.ex_mem_read     = v.mem_read;
        hz_if.ex_rd           = v.rd;
        hz_if.id_rs1          = v.rs1;
        hz_if.id_uses_rs1     = v.u1;
        hz_if.id_rs2          = v.rs2;
        hz_if.id_uses_rs2     = v.u2;
        hz_if.ex_branch_taken = v.br;
        hz_if.imem_ready      = v.imem;
        hz_if.mem_req         = v.req;
        hz_if.dmem_ready      = v.dready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(mk(1, 1'b1, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        vectors++;
        if (ctl !== NONE) begin
            miscompares++;
            $display("FAIL reset_outputs_in_rst ctl=%b expected %b", ctl, NONE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        apply(mk(0, 1'b0, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        vectors++;
        if (ctl !== NONE) begin
            miscompares++;
            $display("FAIL reset_idle ctl=%b expected %b", ctl, NONE);
        end
        vectors++;
        if (hz_if.mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_timeout mem_timeout=%b expected 0", hz_if.mem_timeout);
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (hz_if.stall_cycles !== 32'd0 || hz_if.redirect_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters stall=%0d redir=%0d expected 0 0",
                     hz_if.stall_cycles, hz_if.redirect_count);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        vec_t       v [9];
        logic [6:0] e [9];
        v = '{mk(1, 0, 1, 0, 1), mk(1, 0, 1, 0, 1), mk(1, 0, 1, 0, 1), mk(0, 0, 1, 0, 1),
              mk(2, 0, 1, 0, 1), mk(3, 0, 1, 0, 1), mk(4, 0, 1, 0, 1), mk(0, 0, 1, 0, 1),
              mk(5, 0, 1, 0, 1)};
        e = '{LU, NONE, LU, NONE, NONE, NONE, LU, NONE, NONE};
        for (int i = 0; i < 9; i++) begin
            apply(v[i]);
            @(negedge clk);
            vectors++;
            if (ctl !== e[i]) begin
                miscompares++;
                $display("FAIL load_use[%0d] ctl=%b expected %b", i, ctl, e[i]);
            end
            if (e[i][6]) exp_stall++;
            if (e[i] == BR) exp_redir++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imem_wait();
        vec_t       v [6];
        logic [6:0] e [6];
        v = '{mk(0, 0, 0, 0, 1), mk(0, 0, 0, 0, 1), mk(1, 0, 0, 0, 1), mk(1, 0, 0, 0, 1),
              mk(0, 0, 1, 0, 1), mk(0, 0, 1, 0, 1)};
        e = '{IMW, IMW, LU, IMW, NONE, NONE};
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            @(negedge clk);
            vectors++;
            if (ctl !== e[i]) begin
                miscompares++;
                $display("FAIL imem_wait[%0d] ctl=%b expected %b", i, ctl, e[i]);
            end
            if (e[i][6]) exp_stall++;
            if (e[i] == BR) exp_redir++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        vec_t       v [7];
        logic [6:0] e [7];
        v = '{mk(0, 1, 1, 0, 1), mk(1, 1, 1, 0, 1), mk(0, 0, 1, 0, 1), mk(1, 0, 1, 0, 1),
              mk(1, 1, 1, 0, 1), mk(0, 0, 0, 0, 1), mk(0, 0, 1, 0, 1)};
        e = '{BR, SQ, NONE, LU, BR, SQ, NONE};
        for (int i = 0; i < 7; i++) begin
            apply(v[i]);
            @(negedge clk);
            vectors++;
            if (ctl !== e[i]) begin
                miscompares++;
                $display("FAIL branch[%0d] ctl=%b expected %b", i, ctl, e[i]);
            end
            if (e[i][6]) exp_stall++;
            if (e[i] == BR) exp_redir++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dmem_wait();
        vec_t       v [18];
        logic [6:0] e [18];
        v = '{mk(0, 0, 1, 1, 0), mk(0, 0, 1, 1, 0), mk(0, 0, 1, 1, 0), mk(0, 0, 1, 1, 1),
              mk(0, 0, 1, 0, 1),
              mk(0, 1, 1, 1, 0), mk(0, 1, 1, 1, 0), mk(0, 1, 1, 1, 1), mk(0, 0, 1, 0, 1),
              mk(0, 0, 1, 0, 1),
              mk(0, 1, 1, 0, 1), mk(0, 0, 1, 1, 0), mk(0, 0, 1, 1, 1), mk(0, 0, 1, 0, 1),
              mk(1, 0, 1, 1, 0), mk(1, 0, 1, 1, 1), mk(1, 0, 1, 0, 1), mk(0, 0, 1, 0, 1)};
        e = '{FRZ, FRZ, FRZ, NONE, NONE,
              FRZ, FRZ, BR, SQ, NONE,
              BR, FRZ, NONE, NONE,
              FRZ, LU, NONE, NONE};
        for (int i = 0; i < 18; i++) begin
            apply(v[i]);
            @(negedge clk);
            vectors++;
            if (ctl !== e[i]) begin
                miscompares++;
                $display("FAIL dmem_wait[%0d] ctl=%b expected %b", i, ctl, e[i]);
            end
            vectors++;
            if (hz_if.mem_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL dmem_wait_timeout[%0d] mem_timeout=%b expected 0", i, hz_if.mem_timeout);
            end
            if (e[i][6]) exp_stall++;
            if (e[i] == BR) exp_redir++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        vec_t       v [5];
        logic [6:0] e [5];
        v = '{mk(1, 1, 0, 0, 1), mk(0, 0, 1, 0, 1), mk(1, 1, 0, 1, 0), mk(0, 0, 1, 0, 1),
              mk(0, 0, 1, 0, 1)};
        e = '{BR, SQ, FRZ, NONE, NONE};
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            @(negedge clk);
            vectors++;
            if (ctl !== e[i]) begin
                miscompares++;
                $display("FAIL priority[%0d] ctl=%b expected %b", i, ctl, e[i]);
            end
            if (e[i][6]) exp_stall++;
            if (e[i] == BR) exp_redir++;
            @(posedge clk); #1;
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        vectors++;
        if (hz_if.stall_cycles !== 32'(exp_stall)) begin
            miscompares++;
            $display("FAIL perf_stall_cycles got %0d expected %0d", hz_if.stall_cycles, exp_stall);
        end
        vectors++;
        if (hz_if.redirect_count !== 32'(exp_redir)) begin
            miscompares++;
            $display("FAIL perf_redirect_count got %0d expected %0d", hz_if.redirect_count, exp_redir);
        end
    endtask
`endif

    task automatic test_timeout();
        vec_t       v [7];
        logic [6:0] e [7];
        logic       t [7];
        v = '{mk(0, 0, 1, 1, 0), mk(0, 0, 1, 1, 0), mk(0, 0, 1, 1, 0), mk(0, 0, 1, 1, 0),
              mk(0, 0, 1, 1, 0), mk(0, 0, 1, 0, 1), mk(0, 1, 1, 0, 1)};
        e = '{FRZ, FRZ, FRZ, FRZ, FRZ, FRZ, FRZ};
        t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            apply(v[i]);
            @(negedge clk);
            vectors++;
            if (ctl !== e[i]) begin
                miscompares++;
                $display("FAIL timeout[%0d] ctl=%b expected %b", i, ctl, e[i]);
            end
            vectors++;
            if (hz_if.mem_timeout !== t[i]) begin
                miscompares++;
                $display("FAIL timeout_flag[%0d] mem_timeout=%b expected %b", i, hz_if.mem_timeout, t[i]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        apply(mk(0, 0, 1, 1, 0));
        @(negedge clk);
        vectors++;
        if (ctl !== NONE) begin
            miscompares++;
            $display("FAIL timeout_rst_cycle ctl=%b expected %b", ctl, NONE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        apply(mk(0, 0, 1, 0, 1));
        @(negedge clk);
        vectors++;
        if (ctl !== NONE || hz_if.mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_cleared ctl=%b mem_timeout=%b expected %b 0", ctl, hz_if.mem_timeout, NONE);
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (hz_if.stall_cycles !== 32'd0 || hz_if.redirect_count !== 32'd0) begin
            miscompares++;
            $display("FAIL timeout_counters_cleared stall=%0d redir=%0d expected 0 0",
                     hz_if.stall_cycles, hz_if.redirect_count);
        end
`endif
        @(posedge clk); #1;
        apply(mk(0, 0, 1, 1, 0));
        @(negedge clk);
        vectors++;
        if (ctl !== FRZ || hz_if.mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_rewait ctl=%b mem_timeout=%b expected %b 0", ctl, hz_if.mem_timeout, FRZ);
        end
        @(posedge clk); #1;
        apply(mk(0, 0, 1, 1, 1));
        @(negedge clk);
        vectors++;
        if (ctl !== NONE || hz_if.mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_rewait_release ctl=%b mem_timeout=%b expected %b 0", ctl, hz_if.mem_timeout, NONE);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        apply(mk(0, 1'b0, 1'b1, 1'b0, 1'b1));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_imem_wait();
        test_branch();
        test_dmem_wait();
        test_priority();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
